// File: rtl/system_qsy_sysid_checker_pkg.sv
// Shared definitions for the sysid checker: FSM encoding,
// sysid slave word addresses and wait counter width.
package system_qsy_sysid_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_ID  = 2'd1,
        ST_RD_TS  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam int CNT_W = 16;

endpackage

// File: rtl/system_qsy_sysid_checker.sv
// Reads the Qsys sysid ID and timestamp words over Avalon-MM and
// compares them against the values this build expects.
module system_qsy_sysid_checker
    import system_qsy_sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h5E8D_DE6C,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          AUTO_START     = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [CNT_W-1:0] LIMIT = TIMEOUT_CYCLES[CNT_W-1:0];

    state_t           state;
    state_t           state_next;
    logic             auto_pend;
    logic [CNT_W-1:0] wait_cnt;
    logic             seq_go;
    logic             rd_done;
    logic             rd_tmo;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes are decoded from state so reset drops avm_read at once.
    always_comb begin
        state_next  = state;
        avm_read    = 1'b0;
        avm_address = SYSID_ADDR_ID;
        busy        = 1'b1;
        done        = 1'b0;
        seq_go      = 1'b0;
        rd_done     = 1'b0;
        rd_tmo      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start || auto_pend) begin
                    seq_go     = 1'b1;
                    state_next = ST_RD_ID;
                end
            end
            ST_RD_ID, ST_RD_TS: begin
                avm_read    = 1'b1;
                avm_address = (state == ST_RD_TS) ? SYSID_ADDR_TS
                                                  : SYSID_ADDR_ID;
                if (!avm_waitrequest) begin
                    rd_done    = 1'b1;
                    state_next = (state == ST_RD_ID) ? ST_RD_TS : ST_FINISH;
                end else if (wait_cnt + 16'd1 == LIMIT) begin
                    rd_tmo     = 1'b1;
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_pend <= (AUTO_START != 0);
            wait_cnt  <= '0;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            timeout   <= 1'b0;
            id_value  <= '0;
            ts_value  <= '0;
        end else begin
            if (seq_go) begin
                auto_pend <= 1'b0;
                id_ok     <= 1'b0;
                ts_ok     <= 1'b0;
                timeout   <= 1'b0;
            end
            if (seq_go || rd_done) begin
                wait_cnt <= '0;
            end else if (avm_read && avm_waitrequest) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (rd_done && state == ST_RD_ID) begin
                id_value <= avm_readdata;
                id_ok    <= (avm_readdata == EXPECTED_ID);
            end
            if (rd_done && state == ST_RD_TS) begin
                ts_value <= avm_readdata;
                ts_ok    <= (avm_readdata == EXPECTED_TS);
            end
            if (rd_tmo) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_system_qsy_sysid_checker.sv
// Bench for the sysid checker: a stalling sysid slave model plus
// directed and randomized check sequences against expected outcomes.
module tb_system_qsy_sysid_checker;

    localparam int          T      = 4;
    localparam logic [31:0] GOOD_ID = 32'h0000_0000;
    localparam logic [31:0] GOOD_TS = 32'h5E8D_DE6C;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int          checks = 0;
    int          errors = 0;

    int          stall_id = 0;
    int          stall_ts = 0;
    logic [31:0] word_id = GOOD_ID;
    logic [31:0] word_ts = GOOD_TS;
    int          wcnt;

    logic [31:0] exp_idv = '0;
    logic [31:0] exp_tsv = '0;

    system_qsy_sysid_checker #(
        .EXPECTED_ID(GOOD_ID),
        .EXPECTED_TS(GOOD_TS),
        .TIMEOUT_CYCLES(T),
        .AUTO_START(1)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .busy(busy),
        .done(done),
        .id_ok(id_ok),
        .ts_ok(ts_ok),
        .timeout(timeout),
        .id_value(id_value),
        .ts_value(ts_value)
    );

    always #5 clock = ~clock;

    // Slave: stalls each read for a configured number of cycles.
    assign avm_waitrequest = avm_read &&
        (wcnt < (avm_address ? stall_ts : stall_id));
    assign avm_readdata = avm_address ? word_ts : word_id;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) wcnt <= 0;
        else if (avm_read && avm_waitrequest) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller sits on the negedge where the sequence was triggered.
    task automatic wait_done(input bit poke_busy);
        int   lat;
        int   exp_lat;
        bit   exp_to;
        bit   exp_idok;
        bit   exp_tsok;
        bit   got;
        logic p_rd;
        logic p_addr;
        logic p_wr;
        exp_to   = 1'b0;
        exp_idok = 1'b0;
        exp_tsok = 1'b0;
        if (stall_id >= T) begin
            exp_lat = T + 1;
            exp_to  = 1'b1;
        end else begin
            exp_idv  = word_id;
            exp_idok = (word_id == GOOD_ID);
            if (stall_ts >= T) begin
                exp_lat = stall_id + 2 + T;
                exp_to  = 1'b1;
            end else begin
                exp_lat  = stall_id + stall_ts + 3;
                exp_tsv  = word_ts;
                exp_tsok = (word_ts == GOOD_TS);
            end
        end
        lat = 0;
        got = 1'b0;
        p_rd = 1'b0;
        p_addr = 1'b0;
        p_wr = 1'b0;
        while (lat < 200 && !got) begin
            @(negedge clock);
            lat++;
            start = poke_busy && (lat == 1);
            if (done) begin
                got = 1'b1;
            end else begin
                if (p_rd && p_wr) begin
                    chk("read_stable", avm_read, 1'b1);
                    chk("addr_stable", avm_address, p_addr);
                end
                p_rd = avm_read;
                p_addr = avm_address;
                p_wr = avm_waitrequest;
            end
        end
        chk("done_seen", got, 1'b1);
        chk("latency", lat, exp_lat);
        chk("id_ok", id_ok, exp_idok);
        chk("ts_ok", ts_ok, exp_tsok);
        chk("timeout", timeout, exp_to);
        chk("id_value", id_value, exp_idv);
        chk("ts_value", ts_value, exp_tsv);
        chk("read_off_done", avm_read, 1'b0);
        chk("busy_done", busy, 1'b1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("done_once", done, 1'b0);
        chk("idle_after", busy, 1'b0);
    endtask

    task automatic run_start(input bit poke_busy);
        start = 1'b1;
        wait_done(poke_busy);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_read", avm_read, 1'b0);
        chk("rst_addr", avm_address, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_flags", {id_ok, ts_ok, timeout}, 3'b000);
        chk("rst_idv", id_value, 32'h0);
        chk("rst_tsv", ts_value, 32'h0);
        reset_n = 1'b1;
        wait_done(1'b0);
        repeat (5) @(negedge clock);
        chk("no_reauto", busy, 1'b0);

        word_ts = 32'h5E8D_DE6D;
        run_start(1'b1);
        word_ts = GOOD_TS;
        stall_ts = 99;
        run_start(1'b0);
        stall_id = 3;
        stall_ts = 3;
        run_start(1'b1);
        stall_id = 99;
        run_start(1'b0);

        for (int i = 0; i < 14; i++) begin
            stall_id = $urandom_range(0, 5);
            stall_ts = $urandom_range(0, 5);
            word_id = $urandom_range(0, 1) ? GOOD_ID
                                           : ($urandom | 32'h1);
            word_ts = $urandom_range(0, 1) ? GOOD_TS
                    : (GOOD_TS ^ (32'h1 << $urandom_range(0, 31)));
            run_start($urandom_range(0, 1) == 1);
        end

        stall_id = 0;
        stall_ts = 99;
        word_id = GOOD_ID;
        word_ts = GOOD_TS;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        chk("mid_ts_addr", avm_address, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_read", avm_read, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_flags", {id_ok, ts_ok, timeout}, 3'b000);
        chk("arst_idv", id_value, 32'h0);
        chk("arst_done", done, 1'b0);
        exp_idv = '0;
        exp_tsv = '0;
        stall_ts = 0;
        @(negedge clock);
        chk("arst_nodone", done, 1'b0);
        reset_n = 1'b1;
        wait_done(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
